// File: rtl/simd_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : simd_add_sub
// Purpose  : Packed-lane adder/subtractor. The operand words are split into
//            LANES independent lanes of LANE_W bits. Each lane does a wrapping
//            or saturating add/sub, signed or unsigned. The result is returned
//            LATENCY cycles after an accepted start, together with a
//            one-cycle is_done pulse and per-lane overflow flags.
// Ports    : clk     - clock, all logic on posedge
//            rst     - synchronous active-high reset
//            start   - request, accepted when start=1 and ready=1
//            op      - 00 add-wrap, 01 sub-wrap, 10 add-sat, 11 sub-sat
//            in1/in2 - packed operands, lane i = [i*LANE_W +: LANE_W]
//            ready   - unit can accept start
//            out     - packed result, held until the next completion
//            ovf     - per-lane overflow flag, bit i = lane i
//            is_done - one-cycle pulse, out/ovf updated this cycle
// Revision : 1.0 - initial release
// ============================================================================
module simd_add_sub #(
  parameter int LANES   = 2,
  parameter int LANE_W  = 4,
  parameter int LATENCY = 2,
  parameter int SIGNED  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [LANES*LANE_W-1:0]   in1,
  input  logic [LANES*LANE_W-1:0]   in2,
  output logic                      ready,
  output logic [LANES*LANE_W-1:0]   out,
  output logic [LANES-1:0]          ovf,
  output logic                      is_done
);

  localparam int C_DW    = LANES * LANE_W;
  localparam int C_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_finish;
  logic [C_CNT_W-1:0] r_cnt;
  logic [C_DW-1:0]    r_in1;
  logic [C_DW-1:0]    r_in2;
  logic [1:0]         r_op;
  logic [C_DW-1:0]    w_out;
  logic [LANES-1:0]   w_ovf;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ready is high in the is_done cycle, so a held start is taken back-to-back.
  assign ready = (r_state == IDLE);

  // --------------------------------------------------------------------------
  // Operand capture, latency counter and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_op    <= '0;
      out     <= '0;
      ovf     <= '0;
      is_done <= 1'b0;
    end else begin
      is_done <= w_finish;
      if (w_accept) begin
        r_in1 <= in1;
        r_in2 <= in2;
        r_op  <= op;
        r_cnt <= C_CNT_W'(LATENCY - 1);
      end else if ((r_state == BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - C_CNT_W'(1);
      end
      if (w_finish) begin
        out <= w_out;
        ovf <= w_ovf;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-lane arithmetic on the captured operands. Each lane computes the exact
  // result at LANE_W+1 bits; there is no carry/borrow between lanes.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_W-1:0] w_a;
    logic [LANE_W-1:0] w_b;
    logic [LANE_W:0]   w_ea;
    logic [LANE_W:0]   w_eb;
    logic [LANE_W:0]   w_exact;
    logic              w_lane_ovf;
    logic [LANE_W-1:0] w_sat;

    assign w_a = r_in1[gi*LANE_W +: LANE_W];
    assign w_b = r_in2[gi*LANE_W +: LANE_W];

    if (SIGNED != 0) begin : g_signed
      assign w_ea = {w_a[LANE_W-1], w_a};
      assign w_eb = {w_b[LANE_W-1], w_b};
      // Out of range exactly when the two top bits of the exact result differ;
      // the top bit then gives the true sign, selecting the clamp direction.
      assign w_lane_ovf = w_exact[LANE_W] ^ w_exact[LANE_W-1];
      assign w_sat      = w_exact[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                          : {1'b0, {(LANE_W-1){1'b1}}};
    end else begin : g_unsigned
      assign w_ea = {1'b0, w_a};
      assign w_eb = {1'b0, w_b};
      // Top bit is carry-out for add and borrow (A<B) for sub.
      assign w_lane_ovf = w_exact[LANE_W];
      assign w_sat      = r_op[0] ? {LANE_W{1'b0}} : {LANE_W{1'b1}};
    end

    assign w_exact = r_op[0] ? (w_ea - w_eb) : (w_ea + w_eb);

    assign w_out[gi*LANE_W +: LANE_W] = (r_op[1] && w_lane_ovf) ? w_sat
                                                                 : w_exact[LANE_W-1:0];
    assign w_ovf[gi] = w_lane_ovf;
  end

endmodule
`default_nettype wire

// File: tb/tb_simd_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_simd_add_sub
// Purpose  : Directed self-checking bench for simd_add_sub. Three instances
//            share the stimulus: defaults (signed, LATENCY=2), an unsigned
//            variant, and a LATENCY=3 variant for the handshake sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simd_add_sub;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [7:0] in1;
  logic [7:0] in2;

  logic       s_ready,  u_ready,  l_ready;
  logic [7:0] s_out,    u_out,    l_out;
  logic [1:0] s_ovf,    u_ovf,    l_ovf;
  logic       s_done,   u_done,   l_done;

  int checks;
  int errors;

  simd_add_sub #(.LANES(2), .LANE_W(4), .LATENCY(2), .SIGNED(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
    .ready(s_ready), .out(s_out), .ovf(s_ovf), .is_done(s_done)
  );

  simd_add_sub #(.LANES(2), .LANE_W(4), .LATENCY(2), .SIGNED(0)) u_uns (
    .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
    .ready(u_ready), .out(u_out), .ovf(u_ovf), .is_done(u_done)
  );

  simd_add_sub #(.LANES(2), .LANE_W(4), .LATENCY(3), .SIGNED(1)) u_lat3 (
    .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
    .ready(l_ready), .out(l_out), .ovf(l_ovf), .is_done(l_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One LATENCY=2 operation on the signed (uns=0) or unsigned (uns=1) instance.
  // Operands are scrambled right after acceptance to prove they were captured.
  task automatic run_op(input bit uns, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] o, input logic [7:0] eo,
                        input logic [1:0] ev, input string tag);
    @(negedge clk);
    check({tag, "_rdy_idle"}, uns ? u_ready : s_ready, 1);
    start = 1'b1; in1 = a; in2 = b; op = o;
    @(negedge clk);
    start = 1'b0; in1 = ~a; in2 = ~b; op = ~o;
    check({tag, "_rdy_busy"}, uns ? u_ready : s_ready, 0);
    check({tag, "_done_early1"}, uns ? u_done : s_done, 0);
    @(negedge clk);
    check({tag, "_done_early2"}, uns ? u_done : s_done, 0);
    @(negedge clk);
    check({tag, "_done"}, uns ? u_done : s_done, 1);
    check({tag, "_out"}, uns ? u_out : s_out, eo);
    check({tag, "_ovf"}, uns ? u_ovf : s_ovf, ev);
    check({tag, "_rdy_done"}, uns ? u_ready : s_ready, 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, uns ? u_done : s_done, 0);
    check({tag, "_out_hold"}, uns ? u_out : s_out, eo);
  endtask

  initial begin
    int first_done;
    int second_done;
    int double_done;
    logic rdy_after;
    logic prev_done;

    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00; in1 = 8'h00; in2 = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_out", s_out, 8'h00);
    check("rst_ovf", s_ovf, 2'b00);
    check("rst_done", s_done, 0);
    check("rst_ready", s_ready, 1);
    rst = 1'b0;

    // Signed lanes
    run_op(0, 8'h35, 8'h12, 2'b00, 8'h47, 2'b00, "s_add_wrap");
    run_op(0, 8'h35, 8'h12, 2'b01, 8'h23, 2'b00, "s_sub_wrap");
    run_op(0, 8'h71, 8'h11, 2'b00, 8'h82, 2'b10, "s_add_wrap_ovf");
    run_op(0, 8'h71, 8'h11, 2'b10, 8'h72, 2'b10, "s_add_sat");
    run_op(0, 8'h83, 8'h15, 2'b11, 8'h8E, 2'b10, "s_sub_sat");
    // 0x8 - 0x1 = -9 wraps to 0x7; 0x3 - 0x5 = -2 = 0xE
    run_op(0, 8'h83, 8'h15, 2'b01, 8'h7E, 2'b10, "s_sub_wrap_ovf");

    // Unsigned lanes
    run_op(1, 8'hF0, 8'h11, 2'b10, 8'hF1, 2'b10, "u_add_sat");
    run_op(1, 8'hF0, 8'h11, 2'b00, 8'h01, 2'b10, "u_add_wrap");
    run_op(1, 8'h0F, 8'h1F, 2'b11, 8'h00, 2'b10, "u_sub_sat");
    run_op(1, 8'h0F, 8'h1F, 2'b01, 8'hF0, 2'b10, "u_sub_wrap");

    // start pulsed while busy is ignored and not queued
    @(negedge clk);
    start = 1'b1; in1 = 8'h35; in2 = 8'h12; op = 2'b00;
    @(negedge clk);
    check("ign_rdy_busy", s_ready, 0);
    start = 1'b1; in1 = 8'h71; in2 = 8'h11; op = 2'b10;
    @(negedge clk);
    start = 1'b0;
    check("ign_done_early", s_done, 0);
    @(negedge clk);
    check("ign_done", s_done, 1);
    check("ign_out", s_out, 8'h47);
    check("ign_ovf", s_ovf, 2'b00);
    @(negedge clk);
    check("ign_no_queue1", s_done, 0);
    check("ign_rdy_after", s_ready, 1);
    @(negedge clk);
    check("ign_no_queue2", s_done, 0);
    check("ign_out_hold", s_out, 8'h47);

    // Reset mid-operation aborts without is_done or result update
    @(negedge clk);
    start = 1'b1; in1 = 8'h71; in2 = 8'h11; op = 2'b00;
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_done", s_done, 0);
    check("abort_out", s_out, 8'h00);
    check("abort_ovf", s_ovf, 2'b00);
    check("abort_ready", s_ready, 1);
    @(negedge clk);
    check("abort_no_late_done", s_done, 0);
    check("abort_out_kept", s_out, 8'h00);
    run_op(0, 8'h35, 8'h12, 2'b00, 8'h47, 2'b00, "post_rst");

    // Simultaneous rst and start: start dropped, results cleared
    @(negedge clk);
    rst = 1'b1; start = 1'b1; in1 = 8'h71; in2 = 8'h11; op = 2'b00;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_ready", s_ready, 1);
    check("rst_start_out", s_out, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_start_no_done", s_done, 0);
    check("rst_start_ready2", s_ready, 1);

    // LATENCY=3 with start held high: first result 3 edges after acceptance
    // on edge 1; the start held in the is_done cycle is accepted on edge 5.
    repeat (2) @(negedge clk);
    first_done = -1; second_done = -1; double_done = 0;
    rdy_after = 1'b1; prev_done = 1'b0;
    start = 1'b1; in1 = 8'h35; in2 = 8'h12; op = 2'b00;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (l_done && prev_done) double_done++;
      if (prev_done && (first_done == c - 1)) rdy_after = l_ready;
      if (l_done) begin
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
      prev_done = l_done;
    end
    start = 1'b0;
    check("lat3_first_done", first_done, 4);
    check("lat3_second_done", second_done, 8);
    check("lat3_rearm_busy", rdy_after, 0);
    check("lat3_single_pulse", double_done, 0);
    check("lat3_out", l_out, 8'h47);
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
